// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci term buffer.
// Optional recurrence checker is enabled by defining FIB_RECUR_CHECK_EN.
package fib_pkg;

  typedef enum logic [1:0] {
    S_WAIT0 = 2'd0,
    S_WAIT1 = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } fib_state_t;

  localparam int unsigned FIB_WIDTH = 10;
  localparam int unsigned FIB_DEPTH = 8;
  localparam int unsigned FIB_IDX_W = 8;
  localparam int unsigned DROP_W    = 8;

  function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fib_sync_fifo.sv
// Synchronous FIFO with a registered head entry; occupancy count separates full from empty.
module fib_sync_fifo #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q, valid_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign rd_nxt  = rd_ptr_q + 1'b1;

  assign do_pop  = pop_i && valid_q && !clr_i;
  assign do_push = push_i && (!full_o || do_pop) && !clr_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    valid_d  = valid_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      head_d   = '0;
      valid_d  = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_nxt;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      // The head register mirrors mem_q[rd_ptr_q]; refresh it from the next slot
      // or straight from the incoming entry when the FIFO would otherwise be empty.
      if (do_pop) begin
        if (cnt_q > CntW'(1)) begin
          head_d  = mem_q[rd_nxt];
          valid_d = 1'b1;
        end else if (do_push) begin
          head_d  = data_i;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end else if (!valid_q && do_push) begin
        head_d  = data_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fib_term_buffer.sv
// Buffers Fibonacci terms with ordinals, flags wrap-around and counts FIFO drops.
// Define FIB_RECUR_CHECK_EN to add the p0+p1 recurrence checker driving mismatch.
module fib_term_buffer
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned DEPTH = FIB_DEPTH,
  parameter int unsigned IDX_W = FIB_IDX_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              overflow,
  output logic              mismatch,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned EntryW = IDX_W + WIDTH;

  fib_state_t        state_q, state_d;
  logic [WIDTH-1:0]  p0_q, p0_d, p1_q, p1_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              offer, push, pop, fifo_full, below_p1;
  logic [EntryW-1:0] fifo_head;

  assign below_p1 = (in_data < p1_q);
  assign pop      = out_valid && out_ready && !clr;
  // A full FIFO still takes the term if the head leaves on the same edge.
  assign push     = offer && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    offer   = 1'b0;
    if (clr) begin
      state_d = S_WAIT0;
      p0_d    = '0;
      p1_d    = '0;
      idx_d   = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else if (in_valid) begin
      unique case (state_q)
        S_WAIT0: begin
          p1_d    = in_data;
          state_d = S_WAIT1;
          offer   = 1'b1;
        end
        S_WAIT1: begin
          p0_d    = p1_q;
          p1_d    = in_data;
          state_d = S_RUN;
          offer   = 1'b1;
        end
        S_RUN: begin
          if (below_p1) begin
            ovf_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            p0_d  = p1_q;
            p1_d  = in_data;
            offer = 1'b1;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: state_d = S_WAIT0;
      endcase
      if (offer) begin
        idx_d = (idx_q == {IDX_W{1'b1}}) ? idx_q : idx_q + 1'b1;
        if (!push) drop_d = drop_sat_inc(drop_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_WAIT0;
      p0_q    <= '0;
      p1_q    <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

`ifdef FIB_RECUR_CHECK_EN
  logic [WIDTH-1:0] sum_exp;
  logic             mis_q, mis_d;

  assign sum_exp = p0_q + p1_q;

  always_comb begin
    mis_d = mis_q;
    if (clr) begin
      mis_d = 1'b0;
    end else if (in_valid && (state_q == S_RUN) && !below_p1 && (in_data != sum_exp)) begin
      mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign mismatch = mis_q;
`else
  // p0 only feeds the recurrence checker; keep it tracked but unconsumed here.
  logic unused_p0;
  assign unused_p0 = ^p0_q;
  assign mismatch  = 1'b0;
`endif

  fib_sync_fifo #(
    .DATA_W(EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (clr),
    .push_i (push),
    .data_i ({idx_q, in_data}),
    .pop_i  (pop),
    .full_o (fifo_full),
    .valid_o(out_valid),
    .data_o (fifo_head)
  );

  assign {out_index, out_data} = fifo_head;
  assign overflow              = ovf_q;
  assign drop_cnt              = drop_q;

endmodule

// File: tb/tb_fib_term_buffer.sv
// Scoreboard bench for fib_term_buffer: stimulus queues expected outputs, a monitor checks them.
module tb_fib_term_buffer;
  import fib_pkg::*;

  localparam int W  = 10;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          overflow;
  logic          mismatch;
  logic [7:0]    drop_cnt;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  fib_term_buffer #(.WIDTH(W), .DEPTH(8), .IDX_W(IW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .overflow (overflow),
    .mismatch (mismatch),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_out(input int idx, input int data);
    exp_t e;
    e.idx  = IW'(idx);
    e.data = W'(data);
    exp_q.push_back(e);
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = W'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_cycle();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
    chk({name, "_valid_low"}, out_valid, 0);
  endtask

  // Monitor: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (rstn && !clr && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got idx %0d data %0d expected none", out_index, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", int'(out_data), int'(mon_e.data));
        chk("out_index", int'(out_index), int'(mon_e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s1[15];
    s1 = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987};

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full sequence up to the 10-bit wrap
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      expect_out(i, s1[i]);
      send(s1[i]);
    end
    chk("ovf_before_wrap", overflow, 0);
    send(573);
    chk("ovf_after_wrap", overflow, 1);
    send(1000);
    send(1001);
    drain("wrap_drain");
    chk("wrap_overflow_sticky", overflow, 1);
    chk("wrap_mismatch", mismatch, 0);
    chk("wrap_drop_cnt", drop_cnt, 0);

    // Recurrence violation
    out_ready = 1'b0;
    clear_cycle();
    chk("clr_overflow", overflow, 0);
    out_ready = 1'b1;
    expect_out(0, 1); send(1);
    expect_out(1, 2); send(2);
    expect_out(2, 3); send(3);
    chk("mis_before", mismatch, 0);
    expect_out(3, 6); send(6);
`ifdef FIB_RECUR_CHECK_EN
    chk("mis_after", mismatch, 1);
`else
    chk("mis_after", mismatch, 0);
`endif
    drain("mis_drain");

    // Fill with consumer stalled: 8 stored, 2 dropped, head held
    out_ready = 1'b0;
    clear_cycle();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_out(i, s1[i]);
      send(s1[i]);
      chk("hold_data", out_data, 1);
      chk("hold_index", out_index, 0);
    end
    chk("full_drop_cnt", drop_cnt, 2);
    chk("full_valid", out_valid, 1);

    // Full FIFO with simultaneous push and pop
    expect_out(10, 144);
    out_ready = 1'b1;
    send(144);
    chk("pushpop_drop_cnt", drop_cnt, 2);
    drain("full_drain");
    chk("full_drain_drop_cnt", drop_cnt, 2);

    // clr beats in_valid with terms buffered
    out_ready = 1'b0;
    clear_cycle();
    send(1);
    send(2);
    send(3);
    send(5);
    chk("clr_pre_valid", out_valid, 1);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(8);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid_low", out_valid, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    out_ready = 1'b1;
    expect_out(0, 7);
    send(7);
    drain("clr_drain");

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    clear_cycle();
    send(1);
    send(2);
    send(3);
    send(1);
    chk("arst_pre_overflow", overflow, 1);
    chk("arst_pre_valid", out_valid, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_index", out_index, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect_out(0, 4);
    send(4);
    expect_out(1, 9);
    send(9);
    drain("arst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
